// File: rtl/mmio_lite_pkg.sv
`default_nettype none
// ============================================================================
// mmio_lite_pkg : shared state type and AXI response constants
// Revision: 1.0
// ============================================================================
package mmio_lite_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_RESP = 3'd4,
    ST_RSP     = 3'd5
  } mmio_lite_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] AXPROT_DEFAULT = 3'b000;

  function automatic logic resp_is_err(input logic [1:0] resp);
    case (resp)
      RESP_SLVERR, RESP_DECERR: return 1'b1;
      RESP_OKAY, RESP_EXOKAY:   return 1'b0;
      default:                  return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mmio_lite_master.sv
`default_nettype none
// ============================================================================
// mmio_lite_master : single-outstanding AXI4-Lite master for a cmd/rsp stream
// Revision: 1.0
// ============================================================================
module mmio_lite_master
  import mmio_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    m_axi_aclk,
  input  logic                    m_axi_areset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_write,
  output logic [7:0]              err_count,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]              m_axi_awprot,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]              m_axi_arprot,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  localparam int                    STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [7:0]            ERR_MAX    = 8'hFF;
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK  = ~ADDR_WIDTH'(3);

  mmio_lite_state_t r_state;
  mmio_lite_state_t w_state_nxt;

  logic r_aw_done;
  logic r_w_done;
  logic w_aw_done_nxt;
  logic w_w_done_nxt;

  logic r_cmd_ready;
  logic r_awvalid;
  logic r_wvalid;
  logic r_bready;
  logic r_arvalid;
  logic r_rready;
  logic r_rsp_valid;

  logic                  r_write;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_WIDTH-1:0] r_wstrb;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic [1:0]            r_rsp_resp;
  logic                  r_rsp_write;
  logic [7:0]            r_err_count;

  logic       w_cmd_hs;
  logic       w_aw_hs;
  logic       w_w_hs;
  logic       w_b_hs;
  logic       w_ar_hs;
  logic       w_r_hs;
  logic       w_rsp_hs;
  logic [1:0] w_cap_resp;

  assign w_cmd_hs   = cmd_valid & r_cmd_ready;
  assign w_aw_hs    = r_awvalid & m_axi_awready;
  assign w_w_hs     = r_wvalid & m_axi_wready;
  assign w_b_hs     = r_bready & m_axi_bvalid;
  assign w_ar_hs    = r_arvalid & m_axi_arready;
  assign w_r_hs     = r_rready & m_axi_rvalid;
  assign w_rsp_hs   = r_rsp_valid & rsp_ready;
  assign w_cap_resp = w_b_hs ? m_axi_bresp : m_axi_rresp;

  always_comb begin
    w_state_nxt   = r_state;
    w_aw_done_nxt = 1'b0;
    w_w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cmd_hs) begin
          w_state_nxt = cmd_write ? ST_WR_REQ : ST_RD_REQ;
        end
      end
      ST_WR_REQ: begin
        w_aw_done_nxt = r_aw_done | w_aw_hs;
        w_w_done_nxt  = r_w_done | w_w_hs;
        // Both handshakes may land on the same edge; flags clear on exit.
        if (w_aw_done_nxt && w_w_done_nxt) begin
          w_state_nxt   = ST_WR_RESP;
          w_aw_done_nxt = 1'b0;
          w_w_done_nxt  = 1'b0;
        end
      end
      ST_WR_RESP: begin
        if (w_b_hs) begin
          w_state_nxt = ST_RSP;
        end
      end
      ST_RD_REQ: begin
        if (w_ar_hs) begin
          w_state_nxt = ST_RD_RESP;
        end
      end
      ST_RD_RESP: begin
        if (w_r_hs) begin
          w_state_nxt = ST_RSP;
        end
      end
      ST_RSP: begin
        if (w_rsp_hs) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Handshake outputs are decoded from the next state so they are registered.
  always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
    if (m_axi_areset) begin
      r_state     <= ST_IDLE;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_cmd_ready <= 1'b0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_aw_done   <= w_aw_done_nxt;
      r_w_done    <= w_w_done_nxt;
      r_cmd_ready <= (w_state_nxt == ST_IDLE);
      r_awvalid   <= (w_state_nxt == ST_WR_REQ) & ~w_aw_done_nxt;
      r_wvalid    <= (w_state_nxt == ST_WR_REQ) & ~w_w_done_nxt;
      r_bready    <= (w_state_nxt == ST_WR_RESP);
      r_arvalid   <= (w_state_nxt == ST_RD_REQ);
      r_rready    <= (w_state_nxt == ST_RD_RESP);
      r_rsp_valid <= (w_state_nxt == ST_RSP);
    end
  end

  always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
    if (m_axi_areset) begin
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= RESP_OKAY;
      r_rsp_write <= 1'b0;
      r_err_count <= '0;
    end else begin
      if (w_cmd_hs) begin
        r_write <= cmd_write;
        r_addr  <= cmd_addr & ADDR_MASK;
        r_wdata <= cmd_wdata;
        r_wstrb <= cmd_wstrb;
      end
      if (w_b_hs) begin
        r_rsp_rdata <= '0;
        r_rsp_resp  <= m_axi_bresp;
        r_rsp_write <= r_write;
      end else if (w_r_hs) begin
        r_rsp_rdata <= m_axi_rdata;
        r_rsp_resp  <= m_axi_rresp;
        r_rsp_write <= r_write;
      end
      if ((w_b_hs || w_r_hs) && resp_is_err(w_cap_resp) && (r_err_count != ERR_MAX)) begin
        r_err_count <= r_err_count + 8'd1;
      end
    end
  end

  assign cmd_ready     = r_cmd_ready;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_rdata     = r_rsp_rdata;
  assign rsp_resp      = r_rsp_resp;
  assign rsp_write     = r_rsp_write;
  assign err_count     = r_err_count;
  assign m_axi_awaddr  = r_addr;
  assign m_axi_awprot  = AXPROT_DEFAULT;
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_wdata   = r_wdata;
  assign m_axi_wstrb   = r_wstrb;
  assign m_axi_wvalid  = r_wvalid;
  assign m_axi_bready  = r_bready;
  assign m_axi_araddr  = r_addr;
  assign m_axi_arprot  = AXPROT_DEFAULT;
  assign m_axi_arvalid = r_arvalid;
  assign m_axi_rready  = r_rready;

endmodule
`default_nettype wire

// File: tb/tb_mmio_lite_master.sv
`default_nettype none
// ============================================================================
// tb_mmio_lite_master : directed + randomized bench with stub slave and model
// Revision: 1.0
// ============================================================================
module tb_mmio_lite_master;
  import mmio_lite_pkg::*;

  localparam int AW = 4;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr  = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [3:0]    cmd_wstrb = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          rsp_write;
  logic [7:0]    err_count;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;

  mmio_lite_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .m_axi_aclk(clk), .m_axi_areset(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_write(rsp_write), .err_count(err_count),
    .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  // ---------------- stub slave: 4-word register file, programmable delays
  int         aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0] bresp_cfg = RESP_OKAY, rresp_cfg = RESP_OKAY;
  int         aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  int         aw_hs_cnt, w_hs_cnt, b_hs_cnt;
  logic       aw_got, w_got, ar_got;
  logic [AW-1:0] aw_addr_q, ar_addr_q, cur_awaddr, cur_araddr;
  logic [31:0]   w_data_q, cur_wdata;
  logic [3:0]    w_strb_q, cur_wstrb;
  logic [31:0]   smem [4];
  logic aw_hs, w_hs, ar_hs, have_aw, have_w;

  assign aw_hs      = awvalid & awready;
  assign w_hs       = wvalid & wready;
  assign ar_hs      = arvalid & arready;
  assign have_aw    = aw_got | aw_hs;
  assign have_w     = w_got | w_hs;
  assign cur_awaddr = aw_hs ? awaddr : aw_addr_q;
  assign cur_wdata  = w_hs ? wdata : w_data_q;
  assign cur_wstrb  = w_hs ? wstrb : w_strb_q;
  assign cur_araddr = ar_hs ? araddr : ar_addr_q;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      awready <= 1'b0; wready <= 1'b0; arready <= 1'b0;
      bvalid <= 1'b0; bresp <= 2'b00; rvalid <= 1'b0; rresp <= 2'b00; rdata <= '0;
      aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
      aw_addr_q <= '0; ar_addr_q <= '0; w_data_q <= '0; w_strb_q <= '0;
      for (int i = 0; i < 4; i++) smem[i] <= '0;
    end else begin
      if (aw_dly == 0) awready <= 1'b1;
      else if (awready) awready <= 1'b0;
      else if (awvalid) begin
        if (aw_cnt >= aw_dly) begin awready <= 1'b1; aw_cnt <= 0; end
        else aw_cnt <= aw_cnt + 1;
      end
      if (w_dly == 0) wready <= 1'b1;
      else if (wready) wready <= 1'b0;
      else if (wvalid) begin
        if (w_cnt >= w_dly) begin wready <= 1'b1; w_cnt <= 0; end
        else w_cnt <= w_cnt + 1;
      end
      if (ar_dly == 0) arready <= 1'b1;
      else if (arready) arready <= 1'b0;
      else if (arvalid) begin
        if (ar_cnt >= ar_dly) begin arready <= 1'b1; ar_cnt <= 0; end
        else ar_cnt <= ar_cnt + 1;
      end
      if (aw_hs) begin aw_got <= 1'b1; aw_addr_q <= awaddr; aw_hs_cnt <= aw_hs_cnt + 1; end
      if (w_hs)  begin w_got <= 1'b1; w_data_q <= wdata; w_strb_q <= wstrb; w_hs_cnt <= w_hs_cnt + 1; end
      if (ar_hs) begin ar_got <= 1'b1; ar_addr_q <= araddr; end
      if (bvalid && bready) begin
        bvalid <= 1'b0; b_hs_cnt <= b_hs_cnt + 1;
      end else if (!bvalid && have_aw && have_w) begin
        if (b_cnt >= b_dly) begin
          bvalid <= 1'b1; bresp <= bresp_cfg; b_cnt <= 0;
          aw_got <= 1'b0; w_got <= 1'b0;
          if (bresp_cfg == RESP_OKAY)
            smem[cur_awaddr[3:2]] <= merge(smem[cur_awaddr[3:2]], cur_wdata, cur_wstrb);
        end else b_cnt <= b_cnt + 1;
      end
      if (rvalid && rready) begin
        rvalid <= 1'b0;
      end else if (!rvalid && (ar_got || ar_hs)) begin
        if (r_cnt >= r_dly) begin
          rvalid <= 1'b1; rdata <= smem[cur_araddr[3:2]]; rresp <= rresp_cfg;
          ar_got <= 1'b0; r_cnt <= 0;
        end else r_cnt <= r_cnt + 1;
      end
    end
  end

  initial begin aw_hs_cnt = 0; w_hs_cnt = 0; b_hs_cnt = 0; end

  // ---------------- handshake-rule monitor
  logic m_aw_pend, m_w_pend, m_ar_pend, m_aw_done, m_w_done, m_ar_done, m_rsp_pend;
  int   viol = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_aw_pend <= 1'b0; m_w_pend <= 1'b0; m_ar_pend <= 1'b0;
      m_aw_done <= 1'b0; m_w_done <= 1'b0; m_ar_done <= 1'b0; m_rsp_pend <= 1'b0;
    end else begin
      m_aw_pend <= awvalid & ~awready; m_aw_done <= aw_hs;
      m_w_pend  <= wvalid & ~wready;   m_w_done  <= w_hs;
      m_ar_pend <= arvalid & ~arready; m_ar_done <= ar_hs;
      m_rsp_pend <= rsp_valid & ~rsp_ready;
    end
  end
  always @(posedge clk) begin
    if (!rst && ((m_aw_pend && !awvalid) || (m_aw_done && awvalid) ||
                 (m_w_pend && !wvalid) || (m_w_done && wvalid) ||
                 (m_ar_pend && !arvalid) || (m_ar_done && arvalid) ||
                 (m_rsp_pend && !rsp_valid)))
      viol <= viol + 1;
  end

  // ---------------- reference model and checking
  int          n_cmp = 0, n_fail = 0;
  logic [31:0] mmem [4];
  int          exp_err = 0;
  logic [AW-1:0] last_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_cmd(input logic wr, input logic [AW-1:0] addr, input logic [31:0] wd,
                        input logic [3:0] ws, input int hold, output int lat);
    int          guard, aw0, w0, b0;
    logic        seen;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    lat = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws;
    guard = 0;
    while (!cmd_ready && guard < 64) begin @(negedge clk); guard++; end
    check("cmd_accept", 32'(cmd_ready), 1);
    if (!cmd_ready) begin cmd_valid = 1'b0; return; end
    aw0 = aw_hs_cnt; w0 = w_hs_cnt; b0 = b_hs_cnt;
    seen = 1'b0; last_addr = '0;
    do begin
      @(negedge clk);
      cmd_valid = 1'b0;
      lat++;
      if (!seen && (wr ? awvalid : arvalid)) begin
        seen = 1'b1; last_addr = wr ? awaddr : araddr;
      end
    end while (!rsp_valid && lat < 200);
    check("rsp_wait", 32'(rsp_valid), 1);
    if (!rsp_valid) return;
    if (wr) begin
      exp_rdata = 32'd0; exp_resp = bresp_cfg;
      if (bresp_cfg == RESP_OKAY) mmem[addr[3:2]] = merge(mmem[addr[3:2]], wd, ws);
    end else begin
      exp_rdata = mmem[addr[3:2]]; exp_resp = rresp_cfg;
    end
    if ((exp_resp == 2'b10 || exp_resp == 2'b11) && exp_err < 255) exp_err++;
    check("axi_addr", 32'(last_addr), 32'({addr[3:2], 2'b00}));
    check("rsp_rdata", rsp_rdata, exp_rdata);
    check("rsp_resp", 32'(rsp_resp), 32'(exp_resp));
    check("rsp_write", 32'(rsp_write), 32'(wr));
    check("err_count", 32'(err_count), exp_err);
    if (wr) begin
      check("aw_hs_once", aw_hs_cnt - aw0, 1);
      check("w_hs_once", w_hs_cnt - w0, 1);
      check("b_hs_once", b_hs_cnt - b0, 1);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", 32'(rsp_valid), 1);
      check("bp_rsp_rdata", rsp_rdata, exp_rdata);
      check("bp_cmd_ready", 32'(cmd_ready), 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_retired", 32'(rsp_valid), 0);
    check("ready_after_rsp", 32'(cmd_ready), 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, guard;
    logic [AW-1:0] ra;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) mmem[i] = '0;
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 0);
    check("rst_valids", 32'({awvalid, wvalid, arvalid, bready, rready, rsp_valid}), 0);
    check("rst_rsp_fields", 32'({rsp_resp, rsp_write}) | rsp_rdata, 0);
    check("rst_err_count", 32'(err_count), 0);
    check("axprot", 32'({awprot, arprot}), 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_cmd_ready", 32'(cmd_ready), 1);

    // write burst + readback, best-case latency
    for (int i = 0; i < 4; i++) begin
      do_cmd(1'b1, AW'(4 * i), 32'(i + 1), 4'hF, 0, lat);
      check("wr_latency", lat, 3);
    end
    for (int i = 0; i < 4; i++) begin
      do_cmd(1'b0, AW'(4 * i), 32'd0, 4'h0, 0, lat);
      check("rd_latency", lat, 3);
      check("burst_value", rsp_rdata, 32'(i + 1));
    end

    // unaligned read
    do_cmd(1'b0, 4'h7, 32'd0, 4'h0, 0, lat);
    check("unaligned_araddr", 32'(last_addr), 32'h4);

    // AW/W skew: wready well ahead of awready
    aw_dly = 4; w_dly = 1; b_dly = 1;
    do_cmd(1'b1, 4'h4, $urandom, 4'hF, 0, lat);
    check("skew_rules", viol, 0);
    aw_dly = 0; w_dly = 0; b_dly = 0;

    // response backpressure
    do_cmd(1'b1, 4'h8, 32'hDEADBEEF, 4'hF, 0, lat);
    do_cmd(1'b0, 4'h8, 32'd0, 4'h0, 5, lat);
    check("bp_value", rsp_rdata, 32'hDEADBEEF);

    // randomized mix
    for (int n = 0; n < 40; n++) begin
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
      ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
      bresp_cfg = 2'($urandom_range(0, 3)); rresp_cfg = 2'($urandom_range(0, 3));
      do_cmd(1'($urandom_range(0, 1)), 4'($urandom), $urandom, 4'($urandom),
             $urandom_range(0, 2), lat);
    end
    aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
    bresp_cfg = RESP_OKAY; rresp_cfg = RESP_OKAY;

    // reset while AW is waiting
    aw_dly = 10;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'hC; cmd_wdata = 32'h1234_5678; cmd_wstrb = 4'hF;
    guard = 0;
    while (!cmd_ready && guard < 64) begin @(negedge clk); guard++; end
    @(negedge clk);
    cmd_valid = 1'b0;
    guard = 0;
    while (!awvalid && guard < 64) begin @(negedge clk); guard++; end
    check("pre_reset_awvalid", 32'(awvalid), 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valids", 32'({awvalid, wvalid, rsp_valid}), 0);
    check("async_rst_cmd_ready", 32'(cmd_ready), 0);
    check("async_rst_err", 32'(err_count), 0);
    for (int i = 0; i < 4; i++) mmem[i] = '0;
    exp_err = 0;
    aw_dly = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_cmd_ready", 32'(cmd_ready), 1);
    do_cmd(1'b0, 4'hC, 32'd0, 4'h0, 0, lat);
    check("post_rst_read", rsp_rdata, 32'd0);

    // EXOKAY is not an error
    rresp_cfg = RESP_EXOKAY;
    do_cmd(1'b0, 4'h0, 32'd0, 4'h0, 0, lat);
    check("exokay_no_err", 32'(err_count), 0);

    // error counting and saturation
    bresp_cfg = RESP_SLVERR;
    for (int i = 0; i < 3; i++) do_cmd(1'b1, 4'($urandom), $urandom, 4'hF, 0, lat);
    check("slverr_count", 32'(err_count), 3);
    bresp_cfg = RESP_OKAY; rresp_cfg = RESP_DECERR;
    for (int i = 0; i < 300; i++) begin
      ra = 4'($urandom);
      do_cmd(1'b0, ra, 32'd0, 4'h0, 0, lat);
    end
    check("decerr_saturate", 32'(err_count), 255);
    check("axi_rules", viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
